async_pulse_detector: RTL and testbench
=======================================

Name: async_pulse_detector

Overview:
- Captures a short, asynchronous rising-edge event on pulse_in, which may be narrower than one clk period and need not overlap any clk edge.
- Converts each event into exactly one clk-cycle-wide pulse_out in the clk domain.
- Used at clock-domain or pad boundaries where unsynchronised strobes must be counted or acted on by synchronous logic.
- Capture is toggle-based: a flop clocked by pulse_in toggles, the toggle passes through a multi-flop synchroniser, and an edge detector on the synchronised toggle produces pulse_out.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops in the clk domain. Legal range 2..4; elaboration error outside this range.

Ports:
- clk  input  1  system clock; all synchronous logic uses the rising edge.
- async_rst  input  1  asynchronous active-high reset, applied to every flop in the block. One clock; reset is asynchronous and active-high.
- pulse_in  input  1  asynchronous event strobe; its rising edge is the event.
- pulse_out  output  1  one-clk-cycle pulse per detected event; registered output.

Behaviour:
- Reset (async_rst=1, asserted asynchronously):
  - clears the capture toggle, all SYNC_STAGES synchroniser flops, the edge-detect history flop and pulse_out, all to 0;
  - pulse_out is 0 for the whole time async_rst is high;
  - pulse_in edges during reset are ignored.
- async_rst deassertion is synchronised to clk upstream. pulse_in must be low at deassertion.
- Capture flop:
  - clocked by the rising edge of pulse_in, reset by async_rst;
  - on each pulse_in rising edge, tgl <= ~tgl;
  - no minimum high time beyond the flop's minimum pulse width, which is ≥1 ns in simulation;
  - falling edge of pulse_in has no effect;
  - level held high produces only one event.
- Synchroniser: sync[0] <= tgl, sync[i] <= sync[i-1] on each clk rising edge. sync[SYNC_STAGES-1] is the stable toggle.
- Edge detect:
  - prev <= sync[last];
  - pulse_out <= sync[last] ^ prev, registered;
  - both rising and falling transitions of the synchronised toggle count as events.
- Latency:
  - Call the first clk rising edge after the pulse_in rising edge, including setup margin, edge 1.
  - pulse_out rises at edge SYNC_STAGES+1 and falls at edge SYNC_STAGES+2: exactly one cycle high.
  - If pulse_in rises inside the sync[0] setup/hold window, the response may slip one cycle later but is never lost or duplicated.
- Spacing:
  - Events separated by ≥2 clk periods each produce their own pulse_out cycle.
  - Back-to-back pulse_out cycles are legal.
  - Two events between the same pair of clk sampling edges cancel (even toggle count). This is an accepted limitation, documented for integrators, with no error flag.
- Reset mid-operation: async_rst assertion at any time drops pulse_out to 0 immediately and discards any event in flight. No spurious pulse_out after release.
- No combinational path from pulse_in or async_rst to pulse_out other than the asynchronous clear.
- Synthesis constraints:
  - tgl→sync[0] marked as a false path / async crossing;
  - sync flops carry the codebase's synchroniser attribute (ASYNC_REG or equivalent).

Test Plan:
- Reset: async_rst=1 from t=0 to 5 ns, clk period 4 ns (rising edges at 2, 6, 10, …), pulse_in=0 -> pulse_out=0 throughout and after release. No X on pulse_out after first edge in reset.
- Narrow pulse, SYNC_STAGES=2: pulse_in high 15–16 ns, between edges 14 and 18 -> sync[0]=1 at 18, sync[1]=1 at 22, pulse_out=1 from 26 to 30, then 0.
- Two events spaced 8 ns (16 ns and 24 ns) -> two separate one-cycle pulse_out assertions 8 ns apart. Total pulse_out cycles = 2.
- Long level: pulse_in held high for 40 ns -> exactly one pulse_out cycle. Falling edge produces nothing.
- Reset mid-flight: pulse at 15 ns, async_rst=1 at 23 ns (pulse_out would rise at 26) -> pulse_out stays 0; after release with pulse_in low, pulse_out remains 0.
- SYNC_STAGES=3 with the same 15–16 ns pulse -> pulse_out high 30–34 ns, one cycle later than SYNC_STAGES=2.

Source files
------------

// File: rtl/async_pulse_detector_if.sv
// Strobe-side signals of the asynchronous pulse detector.
// The master drives the raw event and the slave returns the clk-domain pulse.
interface async_pulse_detector_if;
  logic pulse_in;
  logic pulse_out;

  modport master (
    output pulse_in,
    input  pulse_out
  );

  modport slave (
    input  pulse_in,
    output pulse_out
  );
endinterface

// File: rtl/async_pulse_detector.sv
// Turns each asynchronous rising edge on pulse_in into one clk-cycle pulse_out.
// The event flips a toggle flop, the toggle is synchronised, and any change of it becomes a pulse.
module async_pulse_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   async_rst,
  async_pulse_detector_if.slave  pulse_if
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("async_pulse_detector: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic                   tgl_q;
  logic                   tgl_d;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   pulse_q;
  logic                   pulse_d;

  assign tgl_d = ~tgl_q;

  // Clocked by the event itself; tgl_q -> sync_q[0] is an unrelated-clock crossing (false path).
  always_ff @(posedge pulse_if.pulse_in or posedge async_rst) begin
    if (async_rst) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_d;
    end
  end

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = tgl_q;
      end else begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  // Either direction of the settled toggle marks one event.
  assign prev_d  = sync_q[SYNC_STAGES-1];
  assign pulse_d = sync_q[SYNC_STAGES-1] ^ prev_q;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_if.pulse_out = pulse_q;

endmodule

// File: tb/tb_async_pulse_detector.sv
// Directed bench for async_pulse_detector at SYNC_STAGES=2 and 3, driven from one shared strobe.
// Expected pulse cycles are queued when an event is fired and retired as pulses appear.
`timescale 1ns/1ps
module tb_async_pulse_detector;

  logic clk;
  logic rst;
  logic pin;
  int   cyc;
  int   tests;
  int   fails;
  int   n_exp;
  int   n2_obs;
  int   n3_obs;
  int   q2[$];
  int   q3[$];

  async_pulse_detector_if if2();
  async_pulse_detector_if if3();
  assign if2.pulse_in = pin;
  assign if3.pulse_in = pin;

  async_pulse_detector #(.SYNC_STAGES(2)) dut2 (
    .clk      (clk),
    .async_rst(rst),
    .pulse_if (if2)
  );

  async_pulse_detector #(.SYNC_STAGES(3)) dut3 (
    .clk      (clk),
    .async_rst(rst),
    .pulse_if (if3)
  );

  // Rising edges at 2, 6, 10, ... ns; cyc equals (t+2)/4 after the edge at t.
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      tests++;
      assert (if2.pulse_out === 1'b0 && if3.pulse_out === 1'b0)
      else begin
        fails++;
        $error("FAIL in_reset cyc=%0d observed=%b/%b expected=0/0", cyc, if2.pulse_out, if3.pulse_out);
      end
    end else begin
      if (if2.pulse_out !== 1'b0) begin
        tests++;
        assert (if2.pulse_out === 1'b1 && q2.size() > 0 && q2[0] == cyc)
        else begin
          fails++;
          $error("FAIL s2_pulse observed val=%b cyc=%0d expected cyc=%0d", if2.pulse_out, cyc,
                 (q2.size() > 0) ? q2[0] : -1);
        end
        if (q2.size() > 0) void'(q2.pop_front());
        n2_obs++;
        $display("[TB] s2 pulse_out at cyc %0d", cyc);
      end
      if (if3.pulse_out !== 1'b0) begin
        tests++;
        assert (if3.pulse_out === 1'b1 && q3.size() > 0 && q3[0] == cyc)
        else begin
          fails++;
          $error("FAIL s3_pulse observed val=%b cyc=%0d expected cyc=%0d", if3.pulse_out, cyc,
                 (q3.size() > 0) ? q3[0] : -1);
        end
        if (q3.size() > 0) void'(q3.pop_front());
        n3_obs++;
        $display("[TB] s3 pulse_out at cyc %0d", cyc);
      end
    end
  end

  task automatic goto(input int t);
    if (t > int'($time)) #(t - int'($time));
  endtask

  // Edge 1 is the first clk edge after t; pulse_out is high in the cycle after edge 1+SYNC_STAGES-1+1.
  task automatic fire(input int t, input int w, input bit push);
    int e1;
    goto(t);
    if (push) begin
      e1 = (t + 2) / 4 + 1;
      q2.push_back(e1 + 2);
      q3.push_back(e1 + 3);
      n_exp++;
    end
    pin = 1'b1;
    #w;
    pin = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    tests++;
    assert (q2.size() == 0 && q3.size() == 0)
    else begin
      fails++;
      $error("FAIL %s pending observed=%0d/%0d expected=0/0", tag, q2.size(), q3.size());
    end
    $display("[TB] %s drained check at %0t", tag, $time);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    n_exp  = 0;
    n2_obs = 0;
    n3_obs = 0;
    rst    = 1'b1;
    pin    = 1'b0;
    #5;
    rst = 1'b0;
    tests++;
    assert (if2.pulse_out === 1'b0 && if3.pulse_out === 1'b0)
    else begin
      fails++;
      $error("FAIL after_reset observed=%b/%b expected=0/0", if2.pulse_out, if3.pulse_out);
    end

    fire(15, 1, 1'b1);
    goto(50);
    check_drained("narrow");

    fire(56, 1, 1'b1);
    fire(64, 1, 1'b1);
    goto(95);
    check_drained("spaced_pair");

    fire(100, 40, 1'b1);
    goto(190);
    check_drained("long_level");

    // Event in flight when reset hits: it must vanish without a trace.
    fire(199, 1, 1'b0);
    goto(207);
    rst = 1'b1;
    #1;
    tests++;
    assert (if2.pulse_out === 1'b0 && if3.pulse_out === 1'b0)
    else begin
      fails++;
      $error("FAIL midflight_rst observed=%b/%b expected=0/0", if2.pulse_out, if3.pulse_out);
    end
    goto(213);
    rst = 1'b0;
    goto(235);
    check_drained("after_midflight");

    fire(239, 1, 1'b1);
    goto(265);
    check_drained("post_reset_event");

    fire(271, 1, 1'b1);
    fire(275, 1, 1'b1);
    goto(298);
    check_drained("back_to_back");

    // Two events inside one sampling window cancel out.
    fire(303, 1, 1'b0);
    fire(305, 1, 1'b0);
    goto(330);
    check_drained("cancel_pair");

    // Reset while pulse_out is high must clear it at once.
    fire(335, 1, 1'b0);
    goto(347);
    tests++;
    assert (if2.pulse_out === 1'b1 && if3.pulse_out === 1'b0)
    else begin
      fails++;
      $error("FAIL pre_rst_high observed=%b/%b expected=1/0", if2.pulse_out, if3.pulse_out);
    end
    rst = 1'b1;
    #0.5;
    tests++;
    assert (if2.pulse_out === 1'b0 && if3.pulse_out === 1'b0)
    else begin
      fails++;
      $error("FAIL rst_drop observed=%b/%b expected=0/0", if2.pulse_out, if3.pulse_out);
    end
    goto(353);
    rst = 1'b0;
    goto(400);
    check_drained("final");

    tests++;
    assert (n2_obs == n_exp && n3_obs == n_exp)
    else begin
      fails++;
      $error("FAIL pulse_count observed=%0d/%0d expected=%0d", n2_obs, n3_obs, n_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
